// File: rtl/fixed_pkg.sv
// Shared definitions for the fixed-point multiplier arbiter: FSM encoding and defaults.
package fixed_pkg;

  localparam int N_DEF       = 32;
  localparam int Q_DEF       = 16;
  localparam int TMO_CYC_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after the pointer, wrapping.
module rr_pick
  import fixed_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  always_comb begin
    logic [IW:0] w_sum;
    w_sum = '0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      if (!o_any && i_req[w_sum[IW-1:0]]) begin
        o_any                 = 1'b1;
        o_gnt[w_sum[IW-1:0]]  = 1'b1;
        o_idx                 = w_sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fixed_mul_arbiter.sv
// Round-robin sharing of one 1-cycle sign-magnitude multiplier among NREQ requesters.
// Optional WAIT timeout with sticky err_o when ARB_TIMEOUT_EN is defined.
module fixed_mul_arbiter
  import fixed_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int Q       = Q_DEF,
  parameter int NREQ    = 4,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*N-1:0] opA_i,
  input  logic [NREQ*N-1:0] opB_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [N-1:0]      result_o,
  output logic              busy_o,
  output logic              mul_valid_o,
  output logic [N-1:0]      mul_opA_o,
  output logic [N-1:0]      mul_opB_o,
  input  logic              mul_ready_i,
  input  logic [N-1:0]      mul_result_i
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              err_o
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Q only describes the operand format; reject a nonsensical setting at elaboration.
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("fixed_mul_arbiter: Q must lie in [0, N-1]");
  end

  state_t          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_idx;
  logic [NREQ-1:0] r_gnt, r_done;
  logic [N-1:0]    r_result, r_opA, r_opB;
  logic            r_busy, r_mul_valid;

  logic [NREQ-1:0] w_pick_gnt;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic [IW-1:0]   w_ptr_nxt;
  logic            w_tmo_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_ptr_nxt = (r_idx == IW'(NREQ-1)) ? '0 : r_idx + 1'b1;

`ifdef ARB_TIMEOUT_EN
  logic [3:0] r_tmo;
  logic       r_err;

  assign w_tmo_hit = (r_state == WAIT) && (r_tmo == 4'(TMO_CYC-1));
  assign err_o     = r_err;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ISSUE) r_tmo <= '0;
      else if (r_state == WAIT) r_tmo <= r_tmo + 1'b1;
      if (w_tmo_hit && !mul_ready_i) r_err <= 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!nrst_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_any) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (mul_ready_i || w_tmo_hit) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_ptr       <= '0;
      r_idx       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_result    <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_busy      <= 1'b0;
      r_mul_valid <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_mul_valid <= 1'b0;
      r_busy      <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_opA       <= opA_i[w_pick_idx*N +: N];
            r_opB       <= opB_i[w_pick_idx*N +: N];
            r_idx       <= w_pick_idx;
            r_gnt       <= w_pick_gnt;
            r_mul_valid <= 1'b1;
          end
        end
        // Operands stay untouched here: the multiplier derives its sign from them live.
        WAIT: begin
          if (mul_ready_i) begin
            r_result <= mul_result_i;
            r_done   <= NREQ'(1) << r_idx;
          end else if (w_tmo_hit) begin
            r_result <= '0;
            r_done   <= NREQ'(1) << r_idx;
          end
        end
        RESP:    r_ptr <= w_ptr_nxt;
        default: ;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign result_o    = r_result;
  assign busy_o      = r_busy;
  assign mul_valid_o = r_mul_valid;
  assign mul_opA_o   = r_opA;
  assign mul_opB_o   = r_opB;

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// Directed bench for fixed_mul_arbiter; covers the timeout path when ARB_TIMEOUT_EN is defined.
module tb_fixed_mul_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic              clk_i;
  logic              nrst_i;
  logic [NREQ-1:0]   req_i;
  logic [NREQ*N-1:0] opA_i;
  logic [NREQ*N-1:0] opB_i;
  logic [NREQ-1:0]   gnt_o;
  logic [NREQ-1:0]   done_o;
  logic [N-1:0]      result_o;
  logic              busy_o;
  logic              mul_valid_o;
  logic [N-1:0]      mul_opA_o;
  logic [N-1:0]      mul_opB_o;
  logic              mul_ready_i;
  logic [N-1:0]      mul_result_i;
`ifdef ARB_TIMEOUT_EN
  logic              err_o;
`endif

  int checks = 0;
  int errors = 0;

  fixed_mul_arbiter #(
    .N       (N),
    .Q       (16),
    .NREQ    (NREQ),
    .TMO_CYC (15)
  ) dut (
    .clk_i        (clk_i),
    .nrst_i       (nrst_i),
    .req_i        (req_i),
    .opA_i        (opA_i),
    .opB_i        (opB_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .busy_o       (busy_o),
    .mul_valid_o  (mul_valid_o),
    .mul_opA_o    (mul_opA_o),
    .mul_opB_o    (mul_opB_o),
    .mul_ready_i  (mul_ready_i),
    .mul_result_i (mul_result_i)
`ifdef ARB_TIMEOUT_EN
    ,
    .err_o        (err_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in for the Q16 sign-magnitude multiplier.
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = (64'(a[30:0]) * 64'(b[30:0])) >> 16;
    return {a[31] ^ b[31], p[30:0]};
  endfunction

  task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
    opA_i[k*N +: N] = a;
    opB_i[k*N +: N] = b;
  endtask

  // Starts in IDLE with req_i already set; ends in the following IDLE cycle.
  task automatic do_op(input string tag, input int k, input logic [31:0] exp_a,
                       input logic [31:0] exp_res);
    logic [3:0]  oh;
    logic [31:0] a_issue;
    oh = 4'b0001 << k;
    step();
    check({tag, " gnt"}, 64'(gnt_o), 64'(oh));
    check({tag, " mul_valid"}, 64'(mul_valid_o), 64'd1);
    check({tag, " opA latched"}, 64'(mul_opA_o), 64'(exp_a));
    check({tag, " busy"}, 64'(busy_o), 64'd1);
    a_issue  = mul_opA_o;
    req_i[k] = 1'b0;
    step();
    check({tag, " gnt cleared"}, 64'(gnt_o), 64'd0);
    check({tag, " mul_valid cleared"}, 64'(mul_valid_o), 64'd0);
    check({tag, " opA stable"}, 64'(mul_opA_o), 64'(a_issue));
    mul_ready_i  = 1'b1;
    mul_result_i = mul_model(mul_opA_o, mul_opB_o);
    step();
    mul_ready_i  = 1'b0;
    mul_result_i = '0;
    check({tag, " done"}, 64'(done_o), 64'(oh));
    check({tag, " result"}, 64'(result_o), 64'(exp_res));
    step();
    check({tag, " done cleared"}, 64'(done_o), 64'd0);
    check({tag, " idle busy"}, 64'(busy_o), 64'd0);
    check({tag, " result held"}, 64'(result_o), 64'(exp_res));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"}, 64'(gnt_o), 64'd0);
    check({tag, " done"}, 64'(done_o), 64'd0);
    check({tag, " result"}, 64'(result_o), 64'd0);
    check({tag, " busy"}, 64'(busy_o), 64'd0);
    check({tag, " mul_valid"}, 64'(mul_valid_o), 64'd0);
    check({tag, " mul_opA"}, 64'(mul_opA_o), 64'd0);
    check({tag, " mul_opB"}, 64'(mul_opB_o), 64'd0);
`ifdef ARB_TIMEOUT_EN
    check({tag, " err"}, 64'(err_o), 64'd0);
`endif
  endtask

  initial begin
    nrst_i       = 1'b0;
    req_i        = '0;
    opA_i        = '0;
    opB_i        = '0;
    mul_ready_i  = 1'b0;
    mul_result_i = '0;
    step();
    step();
    check_all_zero("reset");
    nrst_i = 1'b1;
    step();

    // 1.5 * 2.0 from requester 0
    set_ops(0, 32'h0001_8000, 32'h0002_0000);
    req_i = 4'b0001;
    do_op("t1", 0, 32'h0001_8000, 32'h0003_0000);

    // -1.5 * 2.0 from requester 2
    set_ops(2, 32'h8001_8000, 32'h0002_0000);
    req_i = 4'b0100;
    do_op("t2", 2, 32'h8001_8000, 32'h8003_0000);

    nrst_i = 1'b0;
    step();
    nrst_i = 1'b1;
    step();

    // All four requesting: strict pointer order, 4 cycles apart
    set_ops(0, 32'h0001_0000, 32'h0003_0000);
    set_ops(1, 32'h0002_0000, 32'h8000_8000);
    set_ops(2, 32'h8004_0000, 32'h8000_4000);
    set_ops(3, 32'h0005_0000, 32'h0002_8000);
    req_i = 4'b1111;
    do_op("t3 r0", 0, 32'h0001_0000, 32'h0003_0000);
    do_op("t3 r1", 1, 32'h0002_0000, 32'h8001_0000);
    do_op("t3 r2", 2, 32'h8004_0000, 32'h0001_0000);
    do_op("t3 r3", 3, 32'h0005_0000, 32'h000C_8000);

    // Requester 3 just served: 0 goes first
    req_i = 4'b1001;
    do_op("t4 r0", 0, 32'h0001_0000, 32'h0003_0000);
    do_op("t4 r3", 3, 32'h0005_0000, 32'h000C_8000);

    // Reset during WAIT, then a stray ready pulse
    set_ops(0, 32'h0001_8000, 32'h0002_0000);
    req_i = 4'b0001;
    step();
    check("t5 gnt", 64'(gnt_o), 64'd1);
    req_i = 4'b0000;
    step();
    nrst_i = 1'b0;
    step();
    check_all_zero("t5 in reset");
    nrst_i       = 1'b1;
    mul_ready_i  = 1'b1;
    mul_result_i = 32'hDEAD_BEEF;
    step();
    mul_ready_i  = 1'b0;
    mul_result_i = '0;
    step();
    check("t5 stray done", 64'(done_o), 64'd0);
    check("t5 stray result", 64'(result_o), 64'd0);
    check("t5 stray busy", 64'(busy_o), 64'd0);
    set_ops(1, 32'h8001_8000, 32'h8002_0000);
    req_i = 4'b0010;
    do_op("t5 r1", 1, 32'h8001_8000, 32'h0003_0000);

`ifdef ARB_TIMEOUT_EN
    // Multiplier never answers
    req_i = 4'b0001;
    step();
    check("t6 gnt", 64'(gnt_o), 64'd1);
    req_i = 4'b0000;
    step();
    for (int i = 1; i < 15; i++) begin
      step();
      check("t6 waiting done", 64'(done_o), 64'd0);
    end
    step();
    check("t6 timeout done", 64'(done_o), 64'd1);
    check("t6 timeout result", 64'(result_o), 64'd0);
    check("t6 err set", 64'(err_o), 64'd1);
    step();
    check("t6 err sticky", 64'(err_o), 64'd1);
    check("t6 idle busy", 64'(busy_o), 64'd0);
    nrst_i = 1'b0;
    step();
    check("t6 err reset", 64'(err_o), 64'd0);
    nrst_i = 1'b1;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_mul_arbiter.md
Name: fixed_mul_arbiter

Overview:
- Round-robin scheduler that shares one fixed-point multiplier among NREQ requesters.
- The multiplier uses sign-magnitude Q format, has one-cycle latency and a valid/ready pulse handshake.
- For each operation the block:
  - accepts one request;
  - latches its operands;
  - drives the multiplier and holds its operands stable until the result is captured;
  - returns the product on a shared result bus with a per-requester one-hot done pulse.
- Sits between the timing-core compute clients and the single multiplier instance.

Parameters:
- N, 32, operand/result width (sign-magnitude: sign bit plus N-1 magnitude bits)
- Q, 16, fractional bits; passed through unchanged, not used for arithmetic here
- NREQ, 4, number of requesters (2..8)
- TMO_CYC, 15, WAIT timeout in cycles (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- nrst_i  in  1  reset, synchronous, active-low
- req_i  in  NREQ  per-requester request level
- opA_i  in  NREQ*N  packed operand A; requester k occupies bits [k*N +: N]
- opB_i  in  NREQ*N  packed operand B, same packing
- gnt_o  out  NREQ  one-hot, 1-cycle pulse: operands of that requester accepted
- done_o  out  NREQ  one-hot, 1-cycle pulse: result_o valid for that requester
- result_o  out  N  product of the granted operation
- busy_o  out  1  high whenever state is not IDLE
- mul_valid_o  out  1  multiplier start pulse
- mul_opA_o  out  N  multiplier operand A
- mul_opB_o  out  N  multiplier operand B
- mul_ready_i  in  1  multiplier result-valid pulse
- mul_result_i  in  N  multiplier result
- err_o  out  1  timeout flag; present only when ARB_TIMEOUT_EN is defined

Behaviour:
- Outputs: all registered.
- Reset (nrst_i low at a clock edge):
  - state goes to IDLE and the round-robin pointer to 0;
  - gnt_o, done_o, result_o, mul_valid_o, mul_opA_o, mul_opB_o, busy_o and err_o all go to 0;
  - an in-flight operation is dropped with no done_o;
  - a mul_ready_i arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_i is sampled only in this state.
  - If any bit is set, select the first set bit at or after the pointer, searching upward with wrap from NREQ-1 to 0.
  - Latch that requester's opA/opB into mul_opA_o/mul_opB_o and store its index.
  - Go to ISSUE.
- ISSUE:
  - gnt_o[idx] = 1 and mul_valid_o = 1 for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - mul_opA_o/mul_opB_o held stable, because the multiplier forms its sign bit combinationally from the live operands.
  - On mul_ready_i = 1, capture mul_result_i into result_o and go to RESP.
- RESP:
  - done_o[idx] = 1 for one cycle; result_o is valid.
  - Pointer becomes idx+1, wrapping NREQ-1 to 0.
  - Go to IDLE.
- Latency: req_i seen in IDLE at cycle t → gnt_o at t+1 → done_o at t+3. One operation per 4 cycles.
- Stable values:
  - result_o holds its value until the next capture.
  - mul_opA_o/mul_opB_o hold until the next grant.
- Requester rules:
  - A requester must hold req_i and its operands until it sees its gnt_o, and must drop req_i in the cycle after gnt_o.
  - A req_i still high during RESP is treated as a new request at the next IDLE, after the other requesters in pointer order.
- mul_ready_i outside WAIT is ignored.
- Simultaneous requests: the pointer decides priority; no requester is granted twice while another is waiting.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TMO_CYC without mul_ready_i, go to RESP with result_o = 0 and done_o pulsed.
  - err_o is set sticky; it clears only on reset.
- Undefined: no counter and no err_o port; WAIT waits indefinitely.

Decomposition:
- Shared package fixed_pkg:
  - state encoding constants: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  - default N and Q;
  - TMO_CYC default.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, binary index, any flag.

Test Plan:
1. Reset, then req_i = 4'b0001 with opA = 0x00018000 (1.5) and opB = 0x00020000 (2.0), multiplier model returns after 1 cycle → gnt_o = 0001 at t+1; done_o = 0001 and result_o = 0x00030000 at t+3.
2. Requester 2, opA = 0x80018000 (−1.5) and opB = 0x00020000 → result_o = 0x80030000, done_o = 0100; mul_opA_o is stable from ISSUE through WAIT.
3. req_i = 4'b1111 held continuously, each requester dropping after its own gnt → grants in order 0, 1, 2, 3, spaced 4 cycles apart; pointer wraps to 0.
4. Requester 3 just served, req_i = 4'b1001 → requester 0 is granted before 3 is re-granted.
5. nrst_i low during WAIT, then mul_ready_i pulses → no done_o; all outputs are 0 and the next request is granted normally.
6. ARB_TIMEOUT_EN defined, multiplier model never returns mul_ready_i → done_o pulses 15 WAIT cycles after entering WAIT, result_o = 0, err_o = 1 until reset.
